// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arb_pkg
//  Purpose  : Shared types and constants for the SRAM port arbiter slice.
//             - resp_st_e : response FSM encoding (which requester's read
//                           returns in the current cycle)
//             - owner_e   : which requester drives the SRAM port this cycle
//             - STARVE_CNT_W : width of the starvation counter
//  Revision : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } resp_st_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arb_starve_ctr
//  Purpose  : Counts consecutive data grants taken while an instruction
//             request is waiting, and raises a force flag once the run
//             reaches STARVE_MAX so the arbiter hands the next slot to the
//             instruction side. Only built when SRAM_ARB_STARVE_GUARD_EN is
//             defined.
//  Ports    : clk          - clock, rising edge
//             resetn       - synchronous active-low reset
//             i_inst_req   - instruction request pending
//             i_inst_gnt   - instruction granted this cycle
//             i_data_gnt   - data granted this cycle
//             o_force_inst - instruction side must win this cycle
//  Revision : 1.0  initial release
// ============================================================================
module sram_arb_starve_ctr
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_inst_req,
    input  logic i_inst_gnt,
    input  logic i_data_gnt,
    output logic o_force_inst
);

    localparam logic [STARVE_CNT_W-1:0] c_starve_max = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] r_starve_cnt;

    // The run only counts while inst is actually waiting; any gap in
    // inst_req or an inst grant restarts it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (!i_inst_req || i_inst_gnt) begin
            r_starve_cnt <= '0;
        end else if (i_data_gnt) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign o_force_inst = i_inst_req && (r_starve_cnt == c_starve_max);

endmodule : sram_arb_starve_ctr
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter
//  Purpose  : Shares one single-port synchronous SRAM between the fetch
//             stage (read-only) and the memory stage (read/write). Data has
//             fixed priority; read data is steered back to the requester
//             that was granted one cycle earlier.
//  Config   : SRAM_ARB_STARVE_GUARD_EN - when defined, a starvation counter
//             forces an instruction grant after STARVE_MAX consecutive data
//             grants with inst_req pending. When undefined, data has strict
//             priority.
//  Ports    : clk, resetn (sync, active-low)
//             inst_req/inst_addr -> inst_gnt, inst_rvalid/inst_rdata
//             data_req/data_wen/data_addr/data_wdata
//                                -> data_gnt, data_rvalid/data_rdata
//             sram_en/sram_wen/sram_addr/sram_wdata -> SRAM, sram_rdata <-
//  Revision : 1.0  initial release
// ============================================================================
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    resp_st_e r_resp_st;
    resp_st_e w_resp_nxt;
    owner_e   w_owner;
    logic     w_force_inst;
    logic     w_inst_gnt;
    logic     w_data_gnt;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    sram_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk          (clk),
        .resetn       (resetn),
        .i_inst_req   (inst_req),
        .i_inst_gnt   (w_inst_gnt),
        .i_data_gnt   (w_data_gnt),
        .o_force_inst (w_force_inst)
    );
`else
    assign w_force_inst = 1'b0;
`endif

    // Grant: data wins unless the starvation guard is forcing inst.
    // Nothing is granted while reset is held.
    always_comb begin
        w_inst_gnt = 1'b0;
        w_data_gnt = 1'b0;
        if (resetn) begin
            if (inst_req && (w_force_inst || !data_req)) begin
                w_inst_gnt = 1'b1;
            end else if (data_req) begin
                w_data_gnt = 1'b1;
            end
        end
    end

    assign inst_gnt = w_inst_gnt;
    assign data_gnt = w_data_gnt;

    always_comb begin
        w_owner = OWN_NONE;
        if (w_inst_gnt) begin
            w_owner = OWN_INST;
        end else if (w_data_gnt) begin
            w_owner = OWN_DATA;
        end
    end

    // SRAM port mux; unused fields are held at zero rather than passed
    // through so the SRAM pins stay quiet when not owned.
    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        case (w_owner)
            OWN_INST: begin
                sram_en   = 1'b1;
                sram_addr = inst_addr;
            end
            OWN_DATA: begin
                sram_en    = 1'b1;
                sram_wen   = data_wen;
                sram_addr  = data_addr;
                sram_wdata = data_wdata;
            end
            default: ;
        endcase
    end

    // Response FSM: records whose read is returning next cycle. Writes
    // leave no response behind.
    always_comb begin
        w_resp_nxt = IDLE;
        if (w_inst_gnt) begin
            w_resp_nxt = RESP_I;
        end else if (w_data_gnt && (data_wen == 4'b0000)) begin
            w_resp_nxt = RESP_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_resp_st <= IDLE;
        end else begin
            r_resp_st <= w_resp_nxt;
        end
    end

    // The state may still say RESP_* during the first reset cycle (the
    // grant happened before reset was seen), so gate with resetn to drop
    // the in-flight response.
    always_comb begin
        inst_rvalid = resetn && (r_resp_st == RESP_I);
        data_rvalid = resetn && (r_resp_st == RESP_D);
        inst_rdata  = inst_rvalid ? sram_rdata : '0;
        data_rdata  = data_rvalid ? sram_rdata : '0;
    end

endmodule : sram_port_arbiter
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_port_arbiter
//  Purpose  : Self-checking bench for sram_port_arbiter. Table of per-cycle
//             vectors (inputs + expected grant/SRAM outputs) plus hand
//             sequences for starvation and reset-with-read-in-flight. Read
//             responses are predicted into a scoreboard queue when a read
//             grant is expected and compared on the following cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    sram_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wen    (data_wen),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .sram_en     (sram_en),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: a read returns addr + 0x100 one cycle after enable.
    initial sram_rdata = 32'h0;
    always @(posedge clk) begin
        if (sram_en && (sram_wen == 4'b0000)) begin
            sram_rdata <= sram_addr + 32'h100;
        end
    end

    // Requesters must hold req until granted (reset excepted).
    logic r_ipend = 1'b0;
    logic r_dpend = 1'b0;
    always @(posedge clk) begin
        if (resetn && r_ipend) begin
            assert (inst_req) else $error("FAIL req_drop_inst: got 0 required 1");
        end
        if (resetn && r_dpend) begin
            assert (data_req) else $error("FAIL req_drop_data: got 0 required 1");
        end
        r_ipend <= resetn && inst_req && !inst_gnt;
        r_dpend <= resetn && data_req && !data_gnt;
    end

    typedef struct {
        logic        rn;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [3:0]  dwen;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic        eig;
        logic        edg;
        logic [3:0]  ewen;
        logic [31:0] eaddr;
        logic [31:0] ewd;
    } vec_t;

    typedef struct {
        logic        is_inst;
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t sb[$];
    vec_t  vt[$];
    int    cyc   = 0;
    int    n_vec = 0;
    int    n_err = 0;

    function automatic vec_t mk(logic rn, logic ireq, logic [31:0] iaddr,
                                logic dreq, logic [3:0] dwen, logic [31:0] daddr,
                                logic [31:0] dwd, logic eig, logic edg,
                                logic [3:0] ewen, logic [31:0] eaddr, logic [31:0] ewd);
        vec_t v;
        v.rn = rn;   v.ireq = ireq; v.iaddr = iaddr;
        v.dreq = dreq; v.dwen = dwen; v.daddr = daddr; v.dwd = dwd;
        v.eig = eig; v.edg = edg; v.ewen = ewen; v.eaddr = eaddr; v.ewd = ewd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input vec_t v);
        resp_t       e;
        logic        exp_iv;
        logic        exp_dv;
        logic [31:0] exp_id;
        logic [31:0] exp_dd;
        @(negedge clk);
        resetn     = v.rn;
        inst_req   = v.ireq;
        inst_addr  = v.iaddr;
        data_req   = v.dreq;
        data_wen   = v.dwen;
        data_addr  = v.daddr;
        data_wdata = v.dwd;
        #2;
        exp_iv = 1'b0; exp_dv = 1'b0; exp_id = 32'h0; exp_dd = 32'h0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (v.rn) begin
                if (e.is_inst) begin
                    exp_iv = 1'b1; exp_id = e.data;
                end else begin
                    exp_dv = 1'b1; exp_dd = e.data;
                end
            end
        end
        chk("inst_rvalid", 32'(inst_rvalid), 32'(exp_iv));
        chk("inst_rdata",  inst_rdata, exp_id);
        chk("data_rvalid", 32'(data_rvalid), 32'(exp_dv));
        chk("data_rdata",  data_rdata, exp_dd);
        chk("inst_gnt",    32'(inst_gnt), 32'(v.eig));
        chk("data_gnt",    32'(data_gnt), 32'(v.edg));
        chk("sram_en",     32'(sram_en), 32'(v.eig | v.edg));
        chk("sram_wen",    32'(sram_wen), 32'(v.ewen));
        chk("sram_addr",   sram_addr, v.eaddr);
        chk("sram_wdata",  sram_wdata, v.ewd);
        if (v.rn && v.eig) begin
            sb.push_back('{1'b1, v.iaddr + 32'h100, cyc + 1});
        end else if (v.rn && v.edg && v.dwen == 4'b0000) begin
            sb.push_back('{1'b0, v.daddr + 32'h100, cyc + 1});
        end
        cyc++;
    endtask

    initial begin
        logic ig;
        resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;

        // Reset holds grants and sram_en low despite requests.
        step(mk(1'b0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0));
        step(mk(1'b0, 1'b0, 32'h0,  1'b0, 4'h0, 32'h0,  32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0));

        //        rn    ireq  iaddr     dreq  dwen  daddr     dwd           eig   edg   ewen  eaddr     ewd
        vt.push_back(mk(1'b1, 1'b0, 32'h00, 1'b0, 4'h0, 32'h00, 32'h0,        1'b0, 1'b0, 4'h0, 32'h00, 32'h0));
        vt.push_back(mk(1'b1, 1'b1, 32'h00, 1'b0, 4'h0, 32'h00, 32'h0,        1'b1, 1'b0, 4'h0, 32'h00, 32'h0));
        vt.push_back(mk(1'b1, 1'b1, 32'h04, 1'b0, 4'h0, 32'h00, 32'h0,        1'b1, 1'b0, 4'h0, 32'h04, 32'h0));
        vt.push_back(mk(1'b1, 1'b1, 32'h08, 1'b0, 4'h0, 32'h00, 32'h0,        1'b1, 1'b0, 4'h0, 32'h08, 32'h0));
        vt.push_back(mk(1'b1, 1'b1, 32'h0C, 1'b0, 4'h0, 32'h00, 32'h0,        1'b1, 1'b0, 4'h0, 32'h0C, 32'h0));
        vt.push_back(mk(1'b1, 1'b0, 32'h00, 1'b0, 4'h0, 32'h00, 32'h0,        1'b0, 1'b0, 4'h0, 32'h00, 32'h0));
        // collision: data wins, inst follows
        vt.push_back(mk(1'b1, 1'b1, 32'h20, 1'b1, 4'h0, 32'h40, 32'h0,        1'b0, 1'b1, 4'h0, 32'h40, 32'h0));
        vt.push_back(mk(1'b1, 1'b1, 32'h20, 1'b0, 4'h0, 32'h00, 32'h0,        1'b1, 1'b0, 4'h0, 32'h20, 32'h0));
        vt.push_back(mk(1'b1, 1'b0, 32'h00, 1'b0, 4'h0, 32'h00, 32'h0,        1'b0, 1'b0, 4'h0, 32'h00, 32'h0));
        // partial write: no response
        vt.push_back(mk(1'b1, 1'b0, 32'h00, 1'b1, 4'h3, 32'h80, 32'hDEADBEEF, 1'b0, 1'b1, 4'h3, 32'h80, 32'hDEADBEEF));
        vt.push_back(mk(1'b1, 1'b0, 32'h00, 1'b0, 4'h0, 32'h00, 32'h0,        1'b0, 1'b0, 4'h0, 32'h00, 32'h0));
        // back-to-back data read, inst read, write over pending inst
        vt.push_back(mk(1'b1, 1'b0, 32'h00, 1'b1, 4'h0, 32'h48, 32'h0,        1'b0, 1'b1, 4'h0, 32'h48, 32'h0));
        vt.push_back(mk(1'b1, 1'b1, 32'h50, 1'b0, 4'h0, 32'h00, 32'h0,        1'b1, 1'b0, 4'h0, 32'h50, 32'h0));
        vt.push_back(mk(1'b1, 1'b1, 32'h60, 1'b1, 4'hF, 32'h84, 32'hCAFEF00D, 1'b0, 1'b1, 4'hF, 32'h84, 32'hCAFEF00D));
        vt.push_back(mk(1'b1, 1'b1, 32'h60, 1'b0, 4'h0, 32'h00, 32'h0,        1'b1, 1'b0, 4'h0, 32'h60, 32'h0));
        vt.push_back(mk(1'b1, 1'b0, 32'h00, 1'b0, 4'h0, 32'h00, 32'h0,        1'b0, 1'b0, 4'h0, 32'h00, 32'h0));

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i]);
        end

        // Starvation: both requesters continuously active.
        for (int i = 0; i < 10; i++) begin
`ifdef SRAM_ARB_STARVE_GUARD_EN
            ig = ((i % 5) == 4);
`else
            ig = 1'b0;
`endif
            step(mk(1'b1, 1'b1, 32'h94, 1'b1, 4'h0, 32'h90, 32'h0,
                    ig, !ig, 4'h0, ig ? 32'h94 : 32'h90, 32'h0));
        end

        // Data stops; pending inst gets through, then reset lands on its response.
        step(mk(1'b1, 1'b1, 32'h94, 1'b0, 4'h0, 32'h00, 32'h0, 1'b1, 1'b0, 4'h0, 32'h94, 32'h0));
        step(mk(1'b0, 1'b1, 32'h98, 1'b1, 4'h0, 32'h9C, 32'h0, 1'b0, 1'b0, 4'h0, 32'h00, 32'h0));
        step(mk(1'b0, 1'b1, 32'h98, 1'b1, 4'h0, 32'h9C, 32'h0, 1'b0, 1'b0, 4'h0, 32'h00, 32'h0));
        chk("resp_st_in_reset", 32'(dut.r_resp_st), 32'h0);
        step(mk(1'b1, 1'b0, 32'h00, 1'b0, 4'h0, 32'h00, 32'h0, 1'b0, 1'b0, 4'h0, 32'h00, 32'h0));
        step(mk(1'b1, 1'b0, 32'h00, 1'b0, 4'h0, 32'h00, 32'h0, 1'b0, 1'b0, 4'h0, 32'h00, 32'h0));

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sram_port_arbiter
`default_nettype wire

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM between the fetch stage (read-only instruction requests) and the memory stage (read/write data requests), so the CPU core can run against a unified memory. Data requests have fixed priority, with a starvation guard that forces an instruction grant after a bounded run of data grants. It sits between the core's `inst_sram_*`/`data_sram_*` ports and the physical SRAM. It tracks the owner of each in-flight access so that read data is returned to the correct requester one cycle after its grant.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants tolerated while `inst_req` is pending (range 1–15)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `resetn` in 1: reset, synchronous, active-low
- `inst_req` in 1: instruction read request
- `inst_addr` in ADDR_W: instruction address
- `inst_gnt` out 1: instruction request accepted this cycle
- `inst_rvalid` out 1: `inst_rdata` valid
- `inst_rdata` out DATA_W: instruction read data
- `data_req` in 1: data request
- `data_wen` in 4: byte write enables; 0 = read
- `data_addr` in ADDR_W: data address
- `data_wdata` in DATA_W: write data
- `data_gnt` out 1: data request accepted this cycle
- `data_rvalid` out 1: `data_rdata` valid (reads only)
- `data_rdata` out DATA_W: data read data
- `sram_en` out 1: SRAM enable
- `sram_wen` out 4: SRAM byte write enables
- `sram_addr` out ADDR_W: SRAM address
- `sram_wdata` out DATA_W: SRAM write data
- `sram_rdata` in DATA_W: SRAM read data, one cycle after enable

## Operation
- Grant is combinational each cycle. At most one of `inst_gnt`/`data_gnt` is high.
  - Default: `data_req` wins over `inst_req`.
  - Forced-inst mode (see below): `inst_req` wins.
- The SRAM port muxes combinationally from the granted requester:
  - `sram_en` = any grant.
  - On inst grant: `sram_wen` = 0, `sram_wdata` = 0.
  - With no grant: all SRAM outputs are 0.
- Requesters hold `req` and payload stable until `gnt`. Dropping `req` before `gnt` is illegal (assertion in bench).
- Response FSM, state register `resp_st`, updated every cycle:
  - IDLE: no read in flight.
  - RESP_I: the inst read granted last cycle returns now.
  - RESP_D: the data read granted last cycle returns now.
  - Next state: RESP_I if inst granted; RESP_D if data read granted; IDLE otherwise, including a data write.
  - Any state may transition to any state; back-to-back grants are permitted.
- Response outputs:
  - `inst_rvalid` = (`resp_st` == RESP_I); `data_rvalid` = (`resp_st` == RESP_D).
  - Each `*_rdata` = `sram_rdata` when its `rvalid` is high, else 0.
- Starvation counter `starve_cnt`, 4 bits:
  - Increments on each data grant while `inst_req` is high.
  - Clears on inst grant, or in any cycle where `inst_req` is low.
  - When `starve_cnt` == `STARVE_MAX`, forced-inst mode applies for that cycle; the resulting inst grant clears the counter.

## Timing
- Grant: same cycle as request, zero latency.
- Read data: exactly 1 cycle after grant.
- Throughput: 1 access per cycle, any mix.
- Reset (`resetn` low at edge):
  - `resp_st` = IDLE, `starve_cnt` = 0.
  - While `resetn` is low, grants and `sram_en` are forced to 0.
  - All outputs read 0 in the cycle after reset.
- Reset asserted with a read in flight: the response is discarded and `rvalid` stays 0.
- Simultaneous requests: one grant per cycle. The loser stays pending, and its request is granted no later than `STARVE_MAX`+1 cycles after assertion when the guard is enabled.
- Data write grant: produces no `rvalid`. The write completes at the SRAM edge of the grant cycle.

## Configuration
- `SRAM_ARB_STARVE_GUARD_EN`:
  - Defined: starvation counter and forced-inst mode as above.
  - Undefined: counter removed; data has strict priority, and inst may starve indefinitely.

## Structure
- Shared package `sram_arb_pkg`:
  - `resp_st` encoding: IDLE = 2'd0, RESP_I = 2'd1, RESP_D = 2'd2.
  - Owner enum.
  - `STARVE_CNT_W` = 4.
- Sub-module `sram_arb_starve_ctr`: the counter and force flag, instantiated only under the macro.
- Everything else sits in the top module.

## Test plan
- Inst-only: `inst_req` high for 4 cycles at addresses 0x0, 0x4, 0x8, 0xC, with SRAM model returning addr+0x100 → 4 consecutive `inst_gnt`; `inst_rvalid` one cycle later each time with `inst_rdata` = 0x100, 0x104, 0x108, 0x10C.
- Collision: `inst_req` and a `data_req` read at 0x40 in the same cycle → `data_gnt` that cycle; `inst_gnt` next cycle; `data_rvalid` then `inst_rvalid` on consecutive cycles, never both high.
- Write: `data_req` with `data_wen` = 4'b0011, addr 0x80, wdata 0xDEADBEEF → `sram_wen` = 4'b0011, `sram_wdata` = 0xDEADBEEF in the grant cycle; no `data_rvalid`.
- Starvation (guard on, `STARVE_MAX` = 4): `data_req` and `inst_req` both continuously high → pattern of 4 `data_gnt` then 1 `inst_gnt`, repeating. Guard off: `inst_gnt` never asserts.
- Reset mid-read: `resetn` low in the cycle after an inst grant → `inst_rvalid` = 0 and `resp_st` = IDLE; `sram_en` = 0 while `resetn` is low, despite requests.
